register_file: RTL and testbench



---
 rtl/datapath_pkg.sv | 17 +
 rtl/register_file_read_port.sv | 30 +++
 rtl/register_file.sv | 62 ++++++
 tb/tb_register_file.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_pkg
// Description : Widths and shared types for the single-cycle datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage : datapath_pkg
`default_nettype wire

// File: rtl/register_file_read_port.sv
`default_nettype none
// ============================================================================
// Module      : register_file_read_port
// Description : Combinational NUM_REGS:1 read mux with optional R0 masking.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_read_port #(
    parameter int DATA_W   = datapath_pkg::DATA_W,
    parameter int ADDR_W   = datapath_pkg::ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] w_selected;

    assign w_selected = regs[addr];

    generate
        if (ZERO_REG != 0) begin : g_zero_mask
            assign data_out = (addr == '0) ? '0 : w_selected;
        end else begin : g_no_mask
            assign data_out = w_selected;
        end
    endgenerate

endmodule : register_file_read_port
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : 16x16 register file, two combinational reads, one sync write.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int DATA_W   = datapath_pkg::DATA_W,
    parameter int ADDR_W   = datapath_pkg::ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] data_write,
    input  logic              reg_write,
    output logic [DATA_W-1:0] data_read_1,
    output logic [DATA_W-1:0] data_read_2
);

    localparam int c_num_regs = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [c_num_regs];
    logic              w_write_en;

    // A masked R0 never stores anything, so its write is dropped at the source.
    assign w_write_en = reg_write && !((ZERO_REG != 0) && (rd == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_num_regs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write_en) begin
            r_regs[rd] <= data_write;
        end
    end

    register_file_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_read_port_rs (
        .regs     (r_regs),
        .addr     (rs),
        .data_out (data_read_1)
    );

    register_file_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_read_port_rt (
        .regs     (r_regs),
        .addr     (rt),
        .data_out (data_read_2)
    );

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Scoreboard bench for register_file, ZERO_REG=1 and ZERO_REG=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [3:0]  rs, rt, rd;
    logic [15:0] data_write;
    logic        reg_write;
    logic [15:0] data_read_1, data_read_2;
    logic [15:0] nz_read_1, nz_read_2;

    register_file #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rd(rd),
        .data_write(data_write), .reg_write(reg_write),
        .data_read_1(data_read_1), .data_read_2(data_read_2)
    );

    register_file #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rd(rd),
        .data_write(data_write), .reg_write(reg_write),
        .data_read_1(nz_read_1), .data_read_2(nz_read_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [15:0] e1n;
        logic [15:0] e2n;
    } exp_t;

    exp_t        exp_q[$];
    event        chk_ev;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] mem [16];

    // Reference: plain array; the masked variant simply reads R0 as zero.
    function automatic logic [15:0] ref_read(input bit zr, input logic [3:0] a);
        return (zr && a == 4'd0) ? 16'h0000 : mem[a];
    endfunction

    task automatic push_chk(input string nm);
        exp_t e;
        e.name = nm;
        e.e1   = ref_read(1'b1, rs);
        e.e2   = ref_read(1'b1, rt);
        e.e1n  = ref_read(1'b0, rs);
        e.e2n  = ref_read(1'b0, rt);
        exp_q.push_back(e);
        ->chk_ev;
    endtask

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (rs=%0d rt=%0d) at %0t", nm, got, exp, rs, rt, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(chk_ev);
            #1;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({e.name, ".z.rd1"},  data_read_1, e.e1);
                check({e.name, ".z.rd2"},  data_read_2, e.e2);
                check({e.name, ".nz.rd1"}, nz_read_1,   e.e1n);
                check({e.name, ".nz.rd2"}, nz_read_2,   e.e2n);
            end
        end
    end

    // One cycle: drive at negedge, check before the edge and after it.
    task automatic drive(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] wa,
                         input logic [15:0] d, input logic we, input string nm);
        @(negedge clk);
        rs = a1; rt = a2; rd = wa; data_write = d; reg_write = we;
        #1 push_chk({nm, ".pre"});
        @(posedge clk);
        #1;
        if (we && rst_n) mem[wa] = d;
        push_chk({nm, ".post"});
    endtask

    initial begin : stimulus
        rst_n = 1'b0; rs = '0; rt = '0; rd = '0; data_write = '0; reg_write = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 16; n++) drive(4'(n), 4'(15 - n), 4'd0, 16'h0, 1'b0, "post_reset");

        drive(4'd1, 4'd2, 4'd3, 16'd12, 1'b0, "write_disabled");
        drive(4'd3, 4'd3, 4'd3, 16'd0,  1'b0, "r3_unchanged");
        drive(4'd3, 4'd2, 4'd3, 16'd12, 1'b1, "write_then_read");

        for (int n = 1; n < 16; n++) drive(4'(n), 4'(15 - n), 4'(n), 16'hA000 + 16'(n), 1'b1, "fill");
        for (int n = 0; n < 16; n++) drive(4'(n), 4'(15 - n), 4'd0, 16'h0, 1'b0, "sweep");
        drive(4'd7, 4'd7, 4'd0, 16'h0, 1'b0, "same_addr_read");

        drive(4'd0, 4'd0, 4'd0, 16'hFFFF, 1'b1, "r0_write");
        drive(4'd0, 4'd1, 4'd0, 16'h0,    1'b0, "r0_read");

        drive(4'd5, 4'd5, 4'd5, 16'h1234, 1'b1, "rdw_first");
        drive(4'd5, 4'd5, 4'd5, 16'h5678, 1'b1, "rdw_second");
        drive(4'd5, 4'd0, 4'd0, 16'h0,    1'b0, "rdw_hold");

        for (int k = 0; k < 300; k++)
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  16'($urandom), 1'($urandom_range(0, 1)), "random");

        drive(4'd4, 4'd9, 4'd4, 16'hBEEF, 1'b1, "pre_reset_a");
        drive(4'd4, 4'd9, 4'd9, 16'hCAFE, 1'b1, "pre_reset_b");

        // Reset mid-cycle with a write pending: clears at once and wins the edge.
        @(negedge clk);
        rs = 4'd4; rt = 4'd9; rd = 4'd4; data_write = 16'h7777; reg_write = 1'b1;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        #1 push_chk("async_reset");
        @(posedge clk);
        #1 push_chk("reset_overrides_write");
        @(negedge clk);
        rst_n = 1'b1; reg_write = 1'b0;
        for (int n = 0; n < 16; n++) drive(4'(n), 4'(15 - n), 4'd0, 16'h0, 1'b0, "after_reset");

        #5;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_register_file
`default_nettype wire
